// File: rtl/ov7670_config_seq_if.sv
// SCCB write-request channel between the configuration sequencer (master)
// and the SCCB write engine (slave). A transfer happens on any rising edge
// where sccb_req and sccb_ready are both high.
interface ov7670_config_seq_if;
  logic       sccb_req;
  logic [7:0] sccb_reg;
  logic [7:0] sccb_val;
  logic       sccb_ready;

  modport master (
    output sccb_req,
    output sccb_reg,
    output sccb_val,
    input  sccb_ready
  );

  modport slave (
    input  sccb_req,
    input  sccb_reg,
    input  sccb_val,
    output sccb_ready
  );
endinterface

// File: rtl/ov7670_config_seq.sv
// OV7670 configuration sequencer: walks the register ROM from address 0,
// turns each word into one SCCB register write, inserts a settling delay for
// 16'hFFF0 and stops at 16'hFFFF or after address 255.
module ov7670_config_seq #(
  parameter int DELAY_CYCLES = 250000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic [7:0]                  rom_addr,
  output logic                        rom_en,
  input  logic [15:0]                 rom_data,
  ov7670_config_seq_if.master         sccb,
  output logic                        busy,
  output logic                        done
);

  localparam int CNT_W = $clog2(DELAY_CYCLES + 1);

  localparam logic [15:0] CODE_END   = 16'hFFFF;
  localparam logic [15:0] CODE_DELAY = 16'hFFF0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_DELAY,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] dly_cnt;

  logic is_end;
  logic is_delay;
  logic xfer;
  logic dly_zero;
  logic advance;
  logic at_ceiling;
  logic restart;

  assign is_end     = (rom_data == CODE_END);
  assign is_delay   = (rom_data == CODE_DELAY);
  assign xfer       = (state == S_SEND) && sccb.sccb_ready;
  assign dly_zero   = (dly_cnt == '0);
  // Finishing a write or a delay entry moves on to the next ROM word.
  assign advance    = xfer || ((state == S_DELAY) && dly_zero);
  // The address saturates at 255 instead of wrapping back to the start.
  assign at_ceiling = (rom_addr == 8'hFF);
  // start is only honoured while idle or done; it is ignored when busy.
  assign restart    = ((state == S_IDLE) || (state == S_DONE)) && start;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_end) begin
          state_nxt = S_DONE;
        end else if (is_delay) begin
          state_nxt = S_DELAY;
        end else begin
          state_nxt = S_SEND;
        end
      end
      S_SEND, S_DELAY: begin
        if (advance) begin
          state_nxt = at_ceiling ? S_DONE : S_FETCH;
        end
      end
      S_DONE:   if (start) state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded purely from state, so reset clears them immediately.
  always_comb begin
    rom_en        = 1'b0;
    sccb.sccb_req = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      S_FETCH:  begin rom_en = 1'b1;        busy = 1'b1; end
      S_DECODE: begin                        busy = 1'b1; end
      S_SEND:   begin sccb.sccb_req = 1'b1; busy = 1'b1; end
      S_DELAY:  begin                        busy = 1'b1; end
      S_DONE:   begin done = 1'b1;                        end
      default:  begin                                     end
    endcase
  end

  // ROM address: cleared on an accepted start, stepped after each entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= 8'h00;
    end else if (restart) begin
      rom_addr <= 8'h00;
    end else if (advance && !at_ceiling) begin
      rom_addr <= rom_addr + 8'd1;
    end
  end

  // Settling counter: loaded on a delay word, counts down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt <= '0;
    end else if ((state == S_DECODE) && is_delay) begin
      dly_cnt <= CNT_W'(DELAY_CYCLES - 1);
    end else if ((state == S_DELAY) && !dly_zero) begin
      dly_cnt <= dly_cnt - CNT_W'(1);
    end
  end

  // Write payload: captured in DECODE and held through any backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sccb.sccb_reg <= 8'h00;
      sccb.sccb_val <= 8'h00;
    end else if ((state == S_DECODE) && !is_end && !is_delay) begin
      sccb.sccb_reg <= rom_data[15:8];
      sccb.sccb_val <= rom_data[7:0];
    end
  end

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Self-checking bench for ov7670_config_seq: a 1-cycle-latency ROM model,
// a write scoreboard fed when each sequence is launched, and one task per
// scenario.
module tb_ov7670_config_seq;

  localparam int DLY = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic        rom_en;
  logic [15:0] rom_data = 16'h0000;
  logic        busy;
  logic        done;

  ov7670_config_seq_if sif ();

  logic [15:0] rom_mem [256];

  int checks     = 0;
  int errors     = 0;
  int xfer_cnt   = 0;
  int fetch_cnt  = 0;
  int zero_fetch = 0;

  logic [15:0] exp_q [$];
  logic [15:0] exp_head;

  ov7670_config_seq #(.DELAY_CYCLES(DLY)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_en   (rom_en),
    .rom_data (rom_data),
    .sccb     (sif),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // ROM model with one cycle of read latency.
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_mem[rom_addr];
  end

  // Monitor: counts fetches and scores every write against the queue.
  always @(negedge clk) begin
    if (rst_n && rom_en) begin
      fetch_cnt++;
      if (rom_addr == 8'h00) zero_fetch++;
    end
    if (rst_n && sif.sccb_req && sif.sccb_ready) begin
      xfer_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_order: got write %h/%h, required no write", sif.sccb_reg, sif.sccb_val);
      end else begin
        exp_head = exp_q.pop_front();
        if ({sif.sccb_reg, sif.sccb_val} !== exp_head) begin
          errors++;
          $display("FAIL write_order: got %h%h, required %h", sif.sccb_reg, sif.sccb_val, exp_head);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic load_basic;
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
    rom_mem[0] = 16'h1280;
    rom_mem[1] = 16'hFFF0;
    rom_mem[2] = 16'h1204;
    rom_mem[3] = 16'hFFFF;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
    sif.sccb_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rom_addr, rom_en, sif.sccb_req, sif.sccb_reg, sif.sccb_val, busy, done} !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0",
               {rom_addr, rom_en, sif.sccb_req, sif.sccb_reg, sif.sccb_val, busy, done});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rom_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b rom_en=%b, required 0 0 0", busy, done, rom_en);
    end
  endtask

  task automatic test_basic;
    int base, fb, n;
    bit ok;
    load_basic();
    exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1204);
    sif.sccb_ready = 1'b1;
    base = xfer_cnt;
    fb   = fetch_cnt;
    pulse_start();
    @(negedge clk);
    checks++;
    if (rom_en !== 1'b1 || rom_addr !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fetch_latency: got rom_en=%b addr=%h busy=%b, required 1 00 1", rom_en, rom_addr, busy);
    end
    @(negedge clk);
    checks++;
    if (rom_en !== 1'b0 || sif.sccb_req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL decode_cycle: got rom_en=%b req=%b busy=%b, required 0 0 1", rom_en, sif.sccb_req, busy);
    end
    @(negedge clk);
    checks++;
    if (sif.sccb_req !== 1'b1 || sif.sccb_reg !== 8'h12 || sif.sccb_val !== 8'h80) begin
      errors++;
      $display("FAIL req_latency: got req=%b reg=%h val=%h, required 1 12 80", sif.sccb_req, sif.sccb_reg, sif.sccb_val);
    end
    // From the first SEND to the FETCH of address 2: FETCH + DECODE + DLY delay cycles + 1.
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n++;
      if (rom_en && rom_addr == 8'h02) break;
    end
    checks++;
    if (n !== DLY + 3) begin
      errors++;
      $display("FAIL delay_span: got %0d cycles, required %0d", n, DLY + 3);
    end
    wait_done(30, ok);
    checks++;
    if (!ok || busy !== 1'b0 || rom_addr !== 8'h03) begin
      errors++;
      $display("FAIL basic_done: got done=%b busy=%b addr=%h, required 1 0 03", done, busy, rom_addr);
    end
    checks++;
    if (xfer_cnt - base !== 2 || exp_q.size() !== 0 || fetch_cnt - fb !== 4) begin
      errors++;
      $display("FAIL basic_counts: got writes=%0d pending=%0d fetches=%0d, required 2 0 4",
               xfer_cnt - base, exp_q.size(), fetch_cnt - fb);
    end
  endtask

  task automatic test_backpressure;
    int base;
    bit ok;
    load_basic();
    exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1204);
    sif.sccb_ready = 1'b0;
    base = xfer_cnt;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sif.sccb_req) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_req_rise: got req=%b, required 1 within 10 cycles", sif.sccb_req);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (sif.sccb_req !== 1'b1 || sif.sccb_reg !== 8'h12 || sif.sccb_val !== 8'h80 || xfer_cnt !== base) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got req=%b reg=%h val=%h writes=%0d, required 1 12 80 0",
                 k, sif.sccb_req, sif.sccb_reg, sif.sccb_val, xfer_cnt - base);
      end
      if (k < 4) @(negedge clk);
    end
    @(posedge clk); #1 sif.sccb_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sif.sccb_req !== 1'b0 || xfer_cnt - base !== 1) begin
      errors++;
      $display("FAIL bp_single_xfer: got req=%b writes=%0d, required 0 1", sif.sccb_req, xfer_cnt - base);
    end
    wait_done(40, ok);
    checks++;
    if (!ok || xfer_cnt - base !== 2 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL bp_done: got done=%b writes=%0d pending=%0d, required 1 2 0", done, xfer_cnt - base, exp_q.size());
    end
  endtask

  task automatic test_start_handling;
    int base, fb;
    bit ok;
    load_basic();
    exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1204);
    sif.sccb_ready = 1'b1;
    base = xfer_cnt;
    fb   = fetch_cnt;
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise: got busy=%b, required 1", busy);
    end
    pulse_start();
    wait_done(40, ok);
    checks++;
    if (!ok || xfer_cnt - base !== 2 || fetch_cnt - fb !== 4) begin
      errors++;
      $display("FAIL start_while_busy: got done=%b writes=%0d fetches=%0d, required 1 2 4",
               done, xfer_cnt - base, fetch_cnt - fb);
    end
    exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1204);
    base = xfer_cnt;
    pulse_start();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || rom_en !== 1'b1 || rom_addr !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_from_done: got done=%b rom_en=%b addr=%h busy=%b, required 0 1 00 1",
               done, rom_en, rom_addr, busy);
    end
    wait_done(40, ok);
    checks++;
    if (!ok || xfer_cnt - base !== 2 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL rerun_writes: got done=%b writes=%0d pending=%0d, required 1 2 0", done, xfer_cnt - base, exp_q.size());
    end
  endtask

  task automatic test_ceiling;
    int base, fb, zb;
    bit ok;
    for (int i = 0; i < 256; i++) begin
      rom_mem[i] = 16'h1111;
      exp_q.push_back(16'h1111);
    end
    sif.sccb_ready = 1'b1;
    base = xfer_cnt;
    fb   = fetch_cnt;
    zb   = zero_fetch;
    pulse_start();
    wait_done(1000, ok);
    checks++;
    if (!ok || rom_addr !== 8'hFF || busy !== 1'b0) begin
      errors++;
      $display("FAIL ceiling_done: got done=%b addr=%h busy=%b, required 1 ff 0", done, rom_addr, busy);
    end
    checks++;
    if (xfer_cnt - base !== 256 || fetch_cnt - fb !== 256 || zero_fetch - zb !== 1 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL ceiling_counts: got writes=%0d fetches=%0d addr0_fetches=%0d pending=%0d, required 256 256 1 0",
               xfer_cnt - base, fetch_cnt - fb, zero_fetch - zb, exp_q.size());
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done !== 1'b1 || rom_addr !== 8'hFF || fetch_cnt - fb !== 256) begin
      errors++;
      $display("FAIL ceiling_no_wrap: got done=%b addr=%h fetches=%0d, required 1 ff 256", done, rom_addr, fetch_cnt - fb);
    end
  endtask

  task automatic test_reset_mid;
    int base, fb;
    bit ok;
    load_basic();
    sif.sccb_ready = 1'b0;
    base = xfer_cnt;
    fb   = fetch_cnt;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sif.sccb_req) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_mid_req: got req=%b, required 1 within 10 cycles", sif.sccb_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rom_addr, rom_en, sif.sccb_req, sif.sccb_reg, sif.sccb_val, busy, done} !== 28'h0) begin
      errors++;
      $display("FAIL rst_mid_async: got %h, required 0",
               {rom_addr, rom_en, sif.sccb_req, sif.sccb_reg, sif.sccb_val, busy, done});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    sif.sccb_ready = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || xfer_cnt !== base || fetch_cnt - fb !== 1) begin
      errors++;
      $display("FAIL rst_mid_idle: got busy=%b done=%b writes=%0d fetches=%0d, required 0 0 0 1",
               busy, done, xfer_cnt - base, fetch_cnt - fb);
    end
  endtask

  task automatic test_immediate_end;
    int base;
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
    sif.sccb_ready = 1'b1;
    base = xfer_cnt;
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL end_early_done: got done=%b busy=%b at T+2, required 0 1", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || rom_addr !== 8'h00 || xfer_cnt !== base) begin
      errors++;
      $display("FAIL end_immediate: got done=%b busy=%b addr=%h writes=%0d, required 1 0 00 0",
               done, busy, rom_addr, xfer_cnt - base);
    end
  endtask

  initial begin
    sif.sccb_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_start_handling();
    test_ceiling();
    test_reset_mid();
    test_immediate_end();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
